// File: rtl/c17_s3.sv
// ISCAS-85 c17 (six 2-input NANDs) pipelined into three register stages,
// one stage per NAND level. One vector per clock, three-edge latency.
module c17_s3 (
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic N6,
    input  logic N7,
    output logic N22,
    output logic N23,
    input  logic clk,
    input  logic rst
);

    logic s1_n10_q, s1_n11_q, s1_n2_q, s1_n7_q;
    logic s1_n10_d, s1_n11_d, s1_n2_d, s1_n7_d;
    logic s2_n16_q, s2_n19_q, s2_n10_q;
    logic s2_n16_d, s2_n19_d, s2_n10_d;
    logic n22_q, n23_q;
    logic n22_d, n23_d;

    // Next-state logic for all three NAND levels; N2, N7 and N10 ride along
    // in balancing flops so every path crosses exactly three registers.
    always_comb begin
        s1_n10_d = ~(N1 & N3);
        s1_n11_d = ~(N3 & N6);
        s1_n2_d  = N2;
        s1_n7_d  = N7;

        s2_n16_d = ~(s1_n2_q & s1_n11_q);
        s2_n19_d = ~(s1_n11_q & s1_n7_q);
        s2_n10_d = s1_n10_q;

        n22_d    = ~(s2_n10_q & s2_n16_q);
        n23_d    = ~(s2_n16_q & s2_n19_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_n10_q <= 1'b0;
            s1_n11_q <= 1'b0;
            s1_n2_q  <= 1'b0;
            s1_n7_q  <= 1'b0;
            s2_n16_q <= 1'b0;
            s2_n19_q <= 1'b0;
            s2_n10_q <= 1'b0;
            n22_q    <= 1'b0;
            n23_q    <= 1'b0;
        end else begin
            s1_n10_q <= s1_n10_d;
            s1_n11_q <= s1_n11_d;
            s1_n2_q  <= s1_n2_d;
            s1_n7_q  <= s1_n7_d;
            s2_n16_q <= s2_n16_d;
            s2_n19_q <= s2_n19_d;
            s2_n10_q <= s2_n10_d;
            n22_q    <= n22_d;
            n23_q    <= n23_d;
        end
    end

    assign N22 = n22_q;
    assign N23 = n23_q;

endmodule

// File: tb/tb_c17_s3.sv
// Bench for c17_s3: directed and random vectors checked against a
// combinational c17 model delayed by three clock edges.
module tb_c17_s3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic N1 = 1'b0, N2 = 1'b0, N3 = 1'b0, N6 = 1'b0, N7 = 1'b0;
    logic N22, N23;

    int n_vec  = 0;
    int n_miss = 0;
    logic [4:0] hist[$];

    c17_s3 dut (
        .N1 (N1),
        .N2 (N2),
        .N3 (N3),
        .N6 (N6),
        .N7 (N7),
        .N22(N22),
        .N23(N23),
        .clk(clk),
        .rst(rst)
    );

    always #10 clk = ~clk;

    // Reference c17 on a packed vector {N1,N2,N3,N6,N7}; returns {N22,N23}.
    function automatic logic [1:0] c17(input logic [4:0] v);
        logic a1, a2, a3, a6, a7, n10, n11, n16, n19;
        {a1, a2, a3, a6, a7} = v;
        n10 = ~(a1 & a3);
        n11 = ~(a3 & a6);
        n16 = ~(a2 & n11);
        n19 = ~(n11 & a7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    task automatic check(input string tag, input logic [1:0] exp);
        n_vec++;
        assert ({N22, N23} === exp)
        else begin
            n_miss++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, {N22, N23}, exp, $time);
        end
    endtask

    // Drive one vector, clock it in, then compare against the vector
    // sampled two edges earlier (i.e. three edges including this one).
    task automatic apply(input string tag, input logic [4:0] v);
        {N1, N2, N3, N6, N7} = v;
        @(posedge clk);
        #1;
        if (rst) begin
            check({tag, "_in_reset"}, 2'b00);
        end else begin
            hist.push_back(v);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3) check(tag, c17(hist[0]));
        end
    endtask

    task automatic async_reset(input string tag);
        #5;
        rst = 1'b1;
        #1;
        check(tag, 2'b00);
        hist.delete();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] stream[5];
        stream = '{5'b10101, 5'b01010, 5'b10011, 5'b11000, 5'b01101};

        // Reset state while rst is held high.
        @(posedge clk);
        #1;
        check("reset_state", 2'b00);
        rst = 1'b0;

        // All-ones after release; first valid result on the third edge.
        repeat (3) apply("all_ones", 5'b11111);

        // Asynchronous assertion mid-cycle clears outputs without an edge.
        apply("pre_async", 5'b10011);
        async_reset("async_rst_now");
        apply("async_rst_hold", 5'b10101);
        apply("async_rst_hold", 5'b01010);
        rst = 1'b0;

        // Directed streaming sequence, then three flush vectors.
        foreach (stream[i]) apply("stream", stream[i]);
        repeat (3) apply("flush", 5'b00000);

        // Alternate the two boundary vectors every cycle.
        for (int i = 0; i < 12; i++) apply("alternate", (i % 2 == 0) ? 5'b00000 : 5'b11111);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 32; i++) apply("exhaustive", 5'(i));
        repeat (2) apply("exh_tail", 5'b11111);

        // Reset with three vectors in flight; only post-release vectors emerge.
        apply("inflight", 5'b10101);
        apply("inflight", 5'b01010);
        apply("inflight", 5'b10011);
        async_reset("midstream_rst");
        apply("midstream_hold", 5'b11000);
        rst = 1'b0;
        apply("post_rst", 5'b01101);
        apply("post_rst", 5'b10011);
        apply("post_rst", 5'b00000);
        apply("post_rst", 5'b11111);

        // Hold constant inputs for ten cycles.
        repeat (10) apply("hold", 5'b10011);

        // Random stream.
        for (int i = 0; i < 64; i++) apply("random", 5'($urandom_range(0, 31)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
